// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data/parity/stop framing and a valid/ready holding register.
// Optional break detection is enabled with `define UART_RX_BREAK_DET_EN (adds o_break).
//
// state        | meaning
// S_IDLE       | line idle, waiting for a synced falling edge
// S_START      | half-bit wait, then confirm start bit is still low
// S_DATA       | mid-bit sampling of DATA_BITS data bits, LSB first
// S_PARITY     | mid-bit sample of the parity bit
// S_STOP       | mid-bit sampling of STOP_BITS stop bits
// S_BREAK_WAIT | break seen, waiting for the line to return high
module uart_rx_param #(
   parameter int CLK_SPEED = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
`ifdef UART_RX_BREAK_DET_EN
   output logic                 o_break,
`endif
   output logic                 o_busy
);

   localparam int CLKS_PER_BIT = CLK_SPEED / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

   generate
      if (CLKS_PER_BIT < 8) begin : g_chk_cpb
         $error("uart_rx_param: CLK_SPEED/BAUD must be at least 8");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
         $error("uart_rx_param: DATA_BITS must be 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_chk_par
         $error("uart_rx_param: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
         $error("uart_rx_param: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q, prev_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 pe_q, pe_d;
   logic                 fe_q, fe_d;
   logic                 done_q, done_d;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q, perr_q, ferr_q, ovr_q;
`ifdef UART_RX_BREAK_DET_EN
   logic                 par_bit_q, par_bit_d;
   logic                 stop_hi_q, stop_hi_d;
   logic                 brk_q, brk_d;
`endif

   logic rx_s, fall, tick, par_xor;
   assign rx_s    = sync2_q;
   assign fall    = prev_q & ~rx_s;
   assign tick    = (cnt_q == '0);
   assign par_xor = ^shift_q ^ rx_s;

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      done_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_d = par_bit_q;
      stop_hi_d = stop_hi_q;
      brk_d     = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (fall) begin
               bit_d   = '0;
               cnt_d   = CNT_HALF;
               pe_d    = 1'b0;
               fe_d    = 1'b0;
               state_d = S_START;
`ifdef UART_RX_BREAK_DET_EN
               par_bit_d = 1'b0;
               stop_hi_d = 1'b0;
`endif
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = CNT_FULL;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               cnt_d   = CNT_FULL;
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               pe_d    = (PARITY == 1) ? ~par_xor : par_xor;
               cnt_d   = CNT_FULL;
               state_d = S_STOP;
`ifdef UART_RX_BREAK_DET_EN
               par_bit_d = rx_s;
`endif
            end
         end
         S_STOP: begin
            if (tick) begin
               cnt_d = CNT_FULL;
               fe_d  = fe_q | ~rx_s;
`ifdef UART_RX_BREAK_DET_EN
               stop_hi_d = stop_hi_q | rx_s;
`endif
               if (bit_q == LAST_STOP) begin
                  // Complete at mid-stop; the remaining half bit is resync slack.
                  state_d = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                  if (shift_q == '0 && !par_bit_q && !stop_hi_q && !rx_s) begin
                     brk_d   = 1'b1;
                     state_d = S_BREAK_WAIT;
                  end else begin
                     done_d = 1'b1;
                  end
`else
                  done_d = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         S_BREAK_WAIT: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         par_bit_q <= 1'b0;
         stop_hi_q <= 1'b0;
         brk_q     <= 1'b0;
`endif
      end else begin
         sync1_q <= i_rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         done_q  <= done_d;
`ifdef UART_RX_BREAK_DET_EN
         par_bit_q <= par_bit_d;
         stop_hi_q <= stop_hi_d;
         brk_q     <= brk_d;
`endif
      end
   end

   // Holding register: a new word may load in the same cycle the old one is accepted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
         end
         if (done_q) begin
            if (!valid_q || i_ready) begin
               data_q  <= shift_q;
               perr_q  <= pe_q;
               ferr_q  <= fe_q;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_parity_err = perr_q;
   assign o_frame_err  = ferr_q;
   assign o_overrun    = ovr_q;
   assign o_busy       = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
   assign o_break      = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four framings (8N1, 8E1, 8O1, 7N2) at 16 clocks per bit.
// Break tests follow UART_RX_BREAK_DET_EN.
module tb_uart_rx_param;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rx  = 4'hF;
   logic [3:0] rdy = 4'hF;
   logic [7:0] d0, d1, d2;
   logic [6:0] d3;
   logic [3:0] v, pe, fe, ov, bz;
`ifdef UART_RX_BREAK_DET_EN
   logic [3:0] brk;
`endif

   always #5 clk = ~clk;

   uart_rx_param #(.CLK_SPEED(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[0]), .o_data(d0), .o_valid(v[0]), .i_ready(rdy[0]),
      .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_overrun(ov[0]),
`ifdef UART_RX_BREAK_DET_EN
      .o_break(brk[0]),
`endif
      .o_busy(bz[0]));

   uart_rx_param #(.CLK_SPEED(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[1]), .o_data(d1), .o_valid(v[1]), .i_ready(rdy[1]),
      .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_overrun(ov[1]),
`ifdef UART_RX_BREAK_DET_EN
      .o_break(brk[1]),
`endif
      .o_busy(bz[1]));

   uart_rx_param #(.CLK_SPEED(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[2]), .o_data(d2), .o_valid(v[2]), .i_ready(rdy[2]),
      .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_overrun(ov[2]),
`ifdef UART_RX_BREAK_DET_EN
      .o_break(brk[2]),
`endif
      .o_busy(bz[2]));

   uart_rx_param #(.CLK_SPEED(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[3]), .o_data(d3), .o_valid(v[3]), .i_ready(rdy[3]),
      .o_parity_err(pe[3]), .o_frame_err(fe[3]), .o_overrun(ov[3]),
`ifdef UART_RX_BREAK_DET_EN
      .o_break(brk[3]),
`endif
      .o_busy(bz[3]));

   int checks = 0;
   int errors = 0;

   // Words accepted by the consumer, captured per DUT.
   int         got_cnt [4];
   logic [8:0] got_d   [4];
   logic       got_pe  [4];
   logic       got_fe  [4];
   int         brk_cnt = 0;

   function automatic logic [8:0] dout(int k);
      case (k)
         0: return {1'b0, d0};
         1: return {1'b0, d1};
         2: return {1'b0, d2};
         default: return {2'b00, d3};
      endcase
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (v[k] && rdy[k]) begin
            got_cnt[k] <= got_cnt[k] + 1;
            got_d[k]   <= dout(k);
            got_pe[k]  <= pe[k];
            got_fe[k]  <= fe[k];
         end
      end
`ifdef UART_RX_BREAK_DET_EN
      if (brk[0]) brk_cnt <= brk_cnt + 1;
`endif
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input int k, input logic b);
      rx[k] = b;
      wait_cyc(CPB);
   endtask

   task automatic send_frame(input int k, input logic [8:0] data, input logic par,
                             input logic s0, input logic s1);
      int nb;
      nb = (k == 3) ? 7 : 8;
      send_bit(k, 1'b0);
      for (int i = 0; i < nb; i++) send_bit(k, data[i]);
      if (k == 1 || k == 2) send_bit(k, par);
      send_bit(k, s0);
      if (k == 3) send_bit(k, s1);
      rx[k] = 1'b1;
   endtask

   typedef struct {
      int         k;
      logic [8:0] data;
      logic       par;
      logic       s0;
      logic       s1;
      logic [8:0] exp_d;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int c0;
      tbl[0] = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
      tbl[1] = '{0, 9'h05A, 1'b0, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b0};
      tbl[2] = '{1, 9'h03C, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0};
      tbl[3] = '{1, 9'h03C, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b1, 1'b0};
      tbl[4] = '{2, 9'h03C, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b1, 1'b0};
      tbl[5] = '{2, 9'h03C, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0};
      tbl[6] = '{3, 9'h055, 1'b0, 1'b1, 1'b0, 9'h055, 1'b0, 1'b1};
      tbl[7] = '{3, 9'h055, 1'b0, 1'b1, 1'b1, 9'h055, 1'b0, 1'b0};
      tbl[8] = '{0, 9'h0A5, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b1};
      tbl[9] = '{3, 9'h02A, 1'b0, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b1};

      // Reset state
      wait_cyc(3);
      chk("rst valid", 32'(v), 32'h0);
      chk("rst busy", 32'(bz), 32'h0);
      chk("rst data0", 32'(d0), 32'h0);
      chk("rst ovr", 32'(ov), 32'h0);
      rst_n = 1'b1;
      wait_cyc(5);

      // Busy drops at mid-stop, before the stop bit has ended
      c0 = got_cnt[0];
      send_bit(0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(0, (8'hA5 >> i) & 8'h01);
      rx[0] = 1'b1;
      wait_cyc(4);
      chk("busy early stop", 32'(bz[0]), 32'h1);
      wait_cyc(10);
      chk("busy after midstop", 32'(bz[0]), 32'h0);
      chk("word by end of stop", 32'(got_cnt[0]), 32'(c0 + 1));
      wait_cyc(8);

      for (int i = 0; i < 10; i++) begin
         c0 = got_cnt[tbl[i].k];
         send_frame(tbl[i].k, tbl[i].data, tbl[i].par, tbl[i].s0, tbl[i].s1);
         wait_cyc(20);
         chk($sformatf("v%0d count", i), 32'(got_cnt[tbl[i].k]), 32'(c0 + 1));
         chk($sformatf("v%0d data", i), 32'(got_d[tbl[i].k]), 32'(tbl[i].exp_d));
         chk($sformatf("v%0d parity_err", i), 32'(got_pe[tbl[i].k]), 32'(tbl[i].exp_pe));
         chk($sformatf("v%0d frame_err", i), 32'(got_fe[tbl[i].k]), 32'(tbl[i].exp_fe));
         chk($sformatf("v%0d valid pulse", i), 32'(v[tbl[i].k]), 32'h0);
      end

      // Glitch: short low pulse is a false start
      c0 = got_cnt[0];
      rx[0] = 1'b0;
      wait_cyc(4);
      rx[0] = 1'b1;
      wait_cyc(2);
      chk("glitch busy", 32'(bz[0]), 32'h1);
      wait_cyc(20);
      chk("glitch idle", 32'(bz[0]), 32'h0);
      chk("glitch no word", 32'(got_cnt[0]), 32'(c0));
      chk("glitch no valid", 32'(v[0]), 32'h0);

      // Overrun: second word dropped while the first is held
      rdy[0] = 1'b0;
      send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1);
      send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1);
      wait_cyc(20);
      chk("ovr valid", 32'(v[0]), 32'h1);
      chk("ovr held data", 32'(d0), 32'h11);
      chk("ovr flag", 32'(ov[0]), 32'h1);
      rdy[0] = 1'b1;
      wait_cyc(1);
      rdy[0] = 1'b0;
      chk("ovr accept valid", 32'(v[0]), 32'h0);
      chk("ovr accept flag", 32'(ov[0]), 32'h0);
      rdy[0] = 1'b1;
      c0 = got_cnt[0];
      send_frame(0, 9'h033, 1'b0, 1'b1, 1'b1);
      wait_cyc(20);
      chk("post ovr count", 32'(got_cnt[0]), 32'(c0 + 1));
      chk("post ovr data", 32'(got_d[0]), 32'h33);
      chk("post ovr flags", 32'({got_pe[0], got_fe[0], ov[0]}), 32'h0);

      // Reset mid-frame with a word held
      rdy[0] = 1'b0;
      send_frame(0, 9'h077, 1'b0, 1'b1, 1'b1);
      wait_cyc(4);
      chk("pre-rst valid", 32'(v[0]), 32'h1);
      send_bit(0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid rst valid", 32'(v[0]), 32'h0);
      chk("mid rst data", 32'(d0), 32'h0);
      chk("mid rst busy", 32'(bz[0]), 32'h0);
      chk("mid rst flags", 32'({pe[0], fe[0], ov[0]}), 32'h0);
      rx[0] = 1'b1;
      wait_cyc(3);
      rst_n = 1'b1;
      rdy[0] = 1'b1;
      wait_cyc(3);
      c0 = got_cnt[0];
      send_frame(0, 9'h00F, 1'b0, 1'b1, 1'b1);
      wait_cyc(20);
      chk("post rst count", 32'(got_cnt[0]), 32'(c0 + 1));
      chk("post rst data", 32'(got_d[0]), 32'h0F);
      chk("post rst flags", 32'({got_pe[0], got_fe[0]}), 32'h0);

      // Line held low for 12 bit times
      c0 = got_cnt[0];
      rx[0] = 1'b0;
      wait_cyc(12 * CPB);
`ifdef UART_RX_BREAK_DET_EN
      chk("break wait busy", 32'(bz[0]), 32'h1);
      rx[0] = 1'b1;
      wait_cyc(20);
      chk("break pulses", 32'(brk_cnt), 32'h1);
      chk("break no word", 32'(got_cnt[0]), 32'(c0));
      chk("break no valid", 32'(v[0]), 32'h0);
      chk("break idle", 32'(bz[0]), 32'h0);
`else
      rx[0] = 1'b1;
      wait_cyc(20);
      chk("break as word", 32'(got_cnt[0]), 32'(c0 + 1));
      chk("break data", 32'(got_d[0]), 32'h0);
      chk("break frame_err", 32'(got_fe[0]), 32'h1);
      chk("break parity_err", 32'(got_pe[0]), 32'h0);
`endif
      c0 = got_cnt[0];
      send_frame(0, 9'h096, 1'b0, 1'b1, 1'b1);
      wait_cyc(20);
      chk("after break count", 32'(got_cnt[0]), 32'(c0 + 1));
      chk("after break data", 32'(got_d[0]), 32'h96);
      chk("after break flags", 32'({got_pe[0], got_fe[0]}), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the team's fixed 8N1 receiver, for the ihex loader and debug console paths.
- Configurable data width, parity and stop bits.
- Start bit is validated at mid-bit; parity, framing and overrun errors are reported.
- Received words are delivered through a valid/ready holding register, so a downstream FIFO or parser can stall without corrupting the word being held.

Parameters:
- CLK_SPEED, 50_000_000: input clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_SPEED/BAUD (integer division). CLKS_PER_BIT must be >= 8; enforced by elaboration check.
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- i_clk, in, 1: sole clock; all logic on rising edge.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_rx, in, 1: asynchronous serial line, idles high.
- o_data, out, DATA_BITS: received word; stable while o_valid.
- o_valid, out, 1: holding register full.
- i_ready, in, 1: consumer accepts the word when o_valid && i_ready.
- o_parity_err, out, 1: parity mismatch for the held word. Valid only with o_valid; always 0 when PARITY=0.
- o_frame_err, out, 1: a stop bit was sampled low for the held word.
- o_overrun, out, 1: sticky; a completed frame was dropped because the holding register was full.
- o_busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - 2FF synchroniser and edge register reset to 1.
  - FSM goes to IDLE; counters and shift register go to 0.
  - o_data, o_valid, o_parity_err, o_frame_err, o_overrun and o_busy all reset to 0.
  - Reset mid-frame discards the partial frame. The receiver then waits for a fresh falling edge.
- Sampling: only the synchronised line is used (i_rx through 2 FFs), plus one extra register for edge detection.
- FSM states and transitions:
  - IDLE: on a synced high-to-low edge, clear the bit counter, load the clock counter, go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is high it is a false start: return to IDLE with no output and no flags. If low, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit, shifting LSB-first into the shift register. After DATA_BITS samples, go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: one mid-bit sample. Compute XOR over data plus the parity bit. Error when: odd mode and XOR = 0; even mode and XOR = 1.
  - STOP: STOP_BITS mid-bit samples; any low sample sets the frame error. At the final stop sample, complete the frame and go to IDLE immediately. There is no wait for the end of the stop bit, giving half a bit of resync slack.
- Frame completion, occurring in the cycle after the final stop sample:
  - If o_valid=0, or o_valid && i_ready in that same cycle: load o_data and both error flags, and set o_valid=1. No overrun.
  - If o_valid && !i_ready: drop the new frame, keep the old word and flags, and set o_overrun=1.
- Handshake:
  - o_valid clears in the cycle after o_valid && i_ready, unless a new word loads in that same cycle.
  - o_overrun clears on any accepted handshake.
  - o_data and the error flags must not change while o_valid && !i_ready.
- Frames with errors are still delivered, with their flags set.
- No combinational path from i_ready to any output.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - Adds output o_break (1 bit, reset 0).
  - A break is a frame whose data, parity (if present) and all stop samples are 0.
  - On a break, no word is loaded and o_valid is unaffected. o_break pulses high for one cycle.
  - The FSM then enters BREAK_WAIT, which counts toward o_busy, until the synced line is sampled high. It then goes to IDLE.
- Undefined:
  - The o_break port is absent.
  - A break is delivered as data 0 with o_frame_err=1; parity error as the arithmetic dictates.
  - Normal falling-edge detection resumes once the line goes high.

Test Plan:
All cases use CLK_SPEED=1_600_000, BAUD=100_000 (CLKS_PER_BIT=16).
- 8N1: send 0xA5 with i_ready=1 -> o_valid pulses 1 cycle, o_data=0xA5, no flags; o_busy falls at mid-stop.
- 8E1: send 0x3C (even, correct parity bit 0) -> parity_err=0. Resend with parity bit 1 -> o_data=0x3C, parity_err=1. Repeat the correct frame with PARITY=1 -> parity_err=1.
- 7N2: send 0x55 with the second stop bit low -> o_data=0x55, frame_err=1. Same frame with both stops high -> frame_err=0.
- Glitch: drive i_rx low for 4 cycles in idle -> no o_valid, o_busy high for ~8 cycles then 0.
- Overrun: i_ready=0, send 0x11 then 0x22 back-to-back -> o_data stays 0x11, o_overrun=1. Pulse i_ready -> o_valid=0, o_overrun=0. Next frame 0x33 received clean.
- Reset: assert i_rst_n=0 mid-DATA of 0xF0 -> all outputs 0 immediately. After release, send 0x0F -> o_data=0x0F, no flags. With the macro defined: hold i_rx low for 12 bits -> o_break one pulse, no o_valid; release line -> next frame received normally.
